// File: rtl/tcdm_lic_xbar_pkg.sv
// Shared helpers for the TCDM logarithmic-interconnect crossbar.
package tcdm_lic_xbar_pkg;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_rr_arb.sv
// NumIn-way round-robin arbiter for one bank: picks a winner, muxes its payload, tracks pointer.
module tcdm_rr_arb
  import tcdm_lic_xbar_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumIn-1:0]                  req_i,
  input  logic [NumIn-1:0][DataWidth-1:0]   data_i,
  input  logic                              gnt_i,
  output logic                              req_o,
  output logic [NumIn-1:0]                  gnt_o,
  output logic [DataWidth-1:0]              data_o
);

  localparam int unsigned PtrW = idx_width(NumIn);

  assign req_o = |req_i;

  if (NumIn == 1) begin : g_single
    assign gnt_o  = req_i & gnt_i;
    assign data_o = req_i[0] ? data_i[0] : '0;
  end else begin : g_multi
    logic [PtrW-1:0] rr_ptr;
    logic [PtrW-1:0] winner;
    logic            found;

    // First requester at or after the pointer, wrapping to index 0.
    always_comb begin
      int unsigned idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int unsigned off = 0; off < NumIn; off++) begin
        idx = 32'(rr_ptr) + off;
        if (idx >= NumIn) idx = idx - NumIn;
        if (!found && req_i[idx]) begin
          found  = 1'b1;
          winner = PtrW'(idx);
        end
      end
    end

    always_comb begin
      gnt_o  = '0;
      data_o = '0;
      if (found) begin
        gnt_o[winner] = gnt_i;
        data_o        = data_i[winner];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rr_ptr <= '0;
      end else if (found && gnt_i) begin
        rr_ptr <= (winner == PtrW'(NumIn - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_lic_xbar.sv
// Full crossbar between TCDM initiators and banks with per-bank round-robin arbitration
// and a fixed-latency response return path.
module tcdm_lic_xbar
  import tcdm_lic_xbar_pkg::*;
#(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned NumOut        = 8,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter bit          WriteRespOn   = 1'b1,
  parameter int unsigned MemLatency    = 1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic [NumIn-1:0]                               req_i,
  input  logic [NumIn-1:0][idx_width(NumOut)-1:0]        add_i,
  input  logic [NumIn-1:0]                               wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]             wdata_i,
  output logic [NumIn-1:0]                               gnt_o,
  output logic [NumIn-1:0]                               vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]            rdata_o,
  output logic [NumOut-1:0]                              req_o,
  input  logic [NumOut-1:0]                              gnt_i,
  output logic [NumOut-1:0][ReqDataWidth-1:0]            wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]           rdata_i
);

  localparam int unsigned BankW = idx_width(NumOut);

  logic [NumOut-1:0][NumIn-1:0] bank_req;
  logic [NumOut-1:0][NumIn-1:0] bank_gnt;

  always_comb begin
    bank_req = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        bank_req[k][j] = req_i[j] && (add_i[j] == BankW'(k));
      end
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_bank
    tcdm_rr_arb #(
      .NumIn     (NumIn),
      .DataWidth (ReqDataWidth)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (bank_req[k]),
      .data_i (wdata_i),
      .gnt_i  (gnt_i[k]),
      .req_o  (req_o[k]),
      .gnt_o  (bank_gnt[k]),
      .data_o (wdata_o[k])
    );
  end

  // Only the addressed bank's arbiter can grant input j.
  always_comb begin
    gnt_o = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      gnt_o[j] = bank_gnt[add_i[j]][j];
    end
  end

  logic [NumIn-1:0][MemLatency-1:0]            pipe_vld;
  logic [NumIn-1:0][MemLatency-1:0][BankW-1:0] pipe_bank;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
    end else begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        pipe_vld[j][0] <= gnt_o[j] & (~wen_i[j] | WriteRespOn);
        for (int unsigned s = 1; s < MemLatency; s++) begin
          pipe_vld[j][s] <= pipe_vld[j][s-1];
        end
      end
    end
  end

  // Bank index is only consumed alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned j = 0; j < NumIn; j++) begin
      pipe_bank[j][0] <= add_i[j];
      for (int unsigned s = 1; s < MemLatency; s++) begin
        pipe_bank[j][s] <= pipe_bank[j][s-1];
      end
    end
  end

  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      vld_o[j] = pipe_vld[j][MemLatency-1];
      if (pipe_vld[j][MemLatency-1]) begin
        rdata_o[j] = rdata_i[pipe_bank[j][MemLatency-1]];
      end
    end
  end

endmodule

// File: tb/tb_tcdm_lic_xbar.sv
// Scoreboard bench for tcdm_lic_xbar: three instances (default, no write response,
// three-cycle latency) share one stimulus stream.
module tb_tcdm_lic_xbar;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           req;
  logic [3:0][2:0]      add;
  logic [3:0]           wen;
  logic [3:0][31:0]     wdata;
  logic [7:0]           bank_gnt;
  logic [7:0][31:0]     bank_rdata;

  logic [3:0]           gnt_a   [3];
  logic [3:0]           vld_a   [3];
  logic [3:0][31:0]     rdata_a [3];
  logic [7:0]           req_a   [3];
  logic [7:0][31:0]     wdat_a  [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int lat   [3] = '{1, 1, 3};
  bit wresp [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    int          due;
    int          inst;
    int          port;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];

  always #5 clk = ~clk;

  tcdm_lic_xbar u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_a[0]), .vld_o(vld_a[0]), .rdata_o(rdata_a[0]), .req_o(req_a[0]),
    .gnt_i(bank_gnt), .wdata_o(wdat_a[0]), .rdata_i(bank_rdata)
  );

  tcdm_lic_xbar #(.WriteRespOn(1'b0)) u_dut_w0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_a[1]), .vld_o(vld_a[1]), .rdata_o(rdata_a[1]), .req_o(req_a[1]),
    .gnt_i(bank_gnt), .wdata_o(wdat_a[1]), .rdata_i(bank_rdata)
  );

  tcdm_lic_xbar #(.MemLatency(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_a[2]), .vld_o(vld_a[2]), .rdata_o(rdata_a[2]), .req_o(req_a[2]),
    .gnt_i(bank_gnt), .wdata_o(wdat_a[2]), .rdata_i(bank_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check grants, queue expected responses, compare responses due now.
  task automatic run_cycle(input string tag, input logic [3:0] exp_gnt);
    resp_t       keep[$];
    logic        exp_v;
    logic [31:0] exp_d;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s gnt inst%0d", tag, i), 64'(gnt_a[i]), 64'(exp_gnt));
    end
    for (int j = 0; j < 4; j++) begin
      if (exp_gnt[j]) begin
        for (int i = 0; i < 3; i++) begin
          if (!wen[j] || wresp[i]) sb.push_back('{cyc + lat[i], i, j, bank_rdata[add[j]]});
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_v = 1'b0;
        exp_d = '0;
        for (int n = 0; n < sb.size(); n++) begin
          if (sb[n].due == cyc && sb[n].inst == i && sb[n].port == j) begin
            exp_v = 1'b1;
            exp_d = sb[n].data;
            sb.delete(n);
            break;
          end
        end
        check_eq($sformatf("%s vld inst%0d port%0d", tag, i, j), 64'(vld_a[i][j]), 64'(exp_v));
        check_eq($sformatf("%s rdata inst%0d port%0d", tag, i, j), 64'(rdata_a[i][j]),
                 64'(exp_d));
      end
    end
    // Reset sampled at the end of this cycle kills everything not yet visible.
    if (rst) begin
      keep = {};
      foreach (sb[n]) if (sb[n].due <= cyc) keep.push_back(sb[n]);
      sb = keep;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req = '0;
    wen = '0;
    repeat (n) run_cycle("drain", 4'b0000);
  endtask

  initial begin
    logic [3:0] e;
    rst      = 1'b1;
    req      = '0;
    add      = '0;
    wen      = '0;
    wdata    = '0;
    bank_gnt = '1;
    for (int k = 0; k < 8; k++) bank_rdata[k] = 32'hB000_0000 | 32'(k);
    bank_rdata[3] = 32'h0000_1234;
    @(negedge clk);

    run_cycle("reset", 4'b0000);
    run_cycle("reset", 4'b0000);
    rst = 1'b0;
    run_cycle("idle", 4'b0000);

    // Single load to bank 3
    req      = 4'b0001;
    add[0]   = 3'd3;
    wdata[0] = 32'hA5;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("load req_o inst%0d", i), 64'(req_a[i]), 64'h08);
      check_eq($sformatf("load wdata_o inst%0d", i), 64'(wdat_a[i][3]), 64'hA5);
    end
    run_cycle("load", 4'b0001);
    drain(4);

    // Four-way conflict on bank 2; pointer wraps on the fifth cycle
    for (int j = 0; j < 4; j++) begin
      add[j]   = 3'd2;
      wdata[j] = 32'h100 + 32'(j);
    end
    req = 4'hF;
    for (int c = 0; c < 5; c++) begin
      e = 4'(1 << (c % 4));
      #1;
      check_eq($sformatf("rr wdata_o c%0d", c), 64'(wdat_a[0][2]), 64'(32'h100 + (c % 4)));
      run_cycle($sformatf("rr c%0d", c), e);
    end
    drain(4);

    // Bank 2 stalled (pointer now 1); bank 0 must still grant independently
    bank_gnt[2] = 1'b0;
    add[0]      = 3'd0;
    add[1]      = 3'd2;
    add[2]      = 3'd2;
    req         = 4'b0111;
    repeat (2) begin
      #1;
      check_eq("stall req_o[2]", 64'(req_a[0][2]), 64'd1);
      run_cycle("stall", 4'b0001);
    end
    bank_gnt[2] = 1'b1;
    req         = 4'b0110;
    run_cycle("unstall", 4'b0010);
    run_cycle("unstall next", 4'b0100);
    drain(4);

    // Parallel requests to distinct banks
    add[0] = 3'd0;
    add[1] = 3'd5;
    add[2] = 3'd7;
    req    = 4'b0111;
    #1;
    check_eq("par req_o", 64'(req_a[0]), 64'hA1);
    run_cycle("par", 4'b0111);
    drain(4);

    // Store on in0 alongside a load on in1
    add[0] = 3'd4;
    add[1] = 3'd6;
    wen    = 4'b0001;
    req    = 4'b0011;
    run_cycle("write", 4'b0011);
    drain(4);

    // Reset one cycle after a grant; pointer must restart at 0
    add[0] = 3'd1;
    req    = 4'b0001;
    run_cycle("pre_rst", 4'b0001);
    req = '0;
    rst = 1'b1;
    run_cycle("rst_mid", 4'b0000);
    rst    = 1'b0;
    add[0] = 3'd1;
    add[1] = 3'd1;
    req    = 4'b0011;
    run_cycle("post_rst", 4'b0001);
    drain(4);

    check_eq("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
